// File: rtl/comp_mac.sv
// Multi-channel unsigned multiply / dot-product / saturating accumulate pipeline.
// Three register stages: operand capture, per-channel products plus their sum, output update.
module comp_mac #(
  parameter int p_size      = 8,
  parameter int p_channels  = 4,
  parameter int p_acc_width = 24
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ena,
  input  logic                           i_mode,
  input  logic                           i_clr,
  input  logic [p_channels*p_size-1:0]   i_param,
  input  logic [p_channels*p_size-1:0]   i_param_2,
  output logic [p_channels*2*p_size-1:0] o_param,
  output logic [p_acc_width-1:0]         o_param_2,
  output logic                           o_sat,
  output logic                           dv
);

  localparam int pw = 2 * p_size;

  // The product sum must fit the accumulator without overflow.
  if (p_acc_width < pw + $clog2(p_channels)) begin : g_param_check
    $error("comp_mac: p_acc_width too small for p_size/p_channels");
  end

  logic [p_channels*p_size-1:0] a_reg, b_reg;
  logic                         mode_s1_reg, clr_s1_reg, valid_s1_reg;

  logic [p_channels*pw-1:0]     prod_next, prod_reg;
  logic [p_acc_width-1:0]       sum_next, sum_reg;
  logic                         mode_s2_reg, clr_s2_reg, valid_s2_reg;

  logic [p_acc_width-1:0]       acc_reg;
  logic [p_acc_width:0]         acc_ext;

  for (genvar gi = 0; gi < p_channels; gi++) begin : g_mul
    assign prod_next[gi*pw +: pw] = {{p_size{1'b0}}, a_reg[gi*p_size +: p_size]}
                                  * {{p_size{1'b0}}, b_reg[gi*p_size +: p_size]};
  end

  always_comb begin
    sum_next = '0;
    for (int k = 0; k < p_channels; k++) begin
      sum_next = sum_next + p_acc_width'(prod_next[k*pw +: pw]);
    end
  end

  assign acc_ext = {1'b0, acc_reg} + {1'b0, sum_reg};

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg        <= '0;
      b_reg        <= '0;
      mode_s1_reg  <= 1'b0;
      clr_s1_reg   <= 1'b0;
      valid_s1_reg <= 1'b0;
    end else begin
      a_reg        <= i_param;
      b_reg        <= i_param_2;
      mode_s1_reg  <= i_mode;
      clr_s1_reg   <= i_clr;
      valid_s1_reg <= ena;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_reg     <= '0;
      sum_reg      <= '0;
      mode_s2_reg  <= 1'b0;
      clr_s2_reg   <= 1'b0;
      valid_s2_reg <= 1'b0;
    end else begin
      prod_reg     <= prod_next;
      sum_reg      <= sum_next;
      mode_s2_reg  <= mode_s1_reg;
      clr_s2_reg   <= clr_s1_reg;
      valid_s2_reg <= valid_s1_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_param   <= '0;
      o_param_2 <= '0;
      acc_reg   <= '0;
      o_sat     <= 1'b0;
      dv        <= 1'b0;
    end else begin
      dv <= valid_s2_reg;
      if (valid_s2_reg) begin
        o_param <= prod_reg;
        if (!mode_s2_reg || clr_s2_reg) begin
          o_param_2 <= sum_reg;
          acc_reg   <= sum_reg;
          o_sat     <= 1'b0;
        end else if (acc_ext[p_acc_width]) begin
          o_param_2 <= '1;
          acc_reg   <= '1;
          o_sat     <= 1'b1;
        end else begin
          o_param_2 <= acc_ext[p_acc_width-1:0];
          acc_reg   <= acc_ext[p_acc_width-1:0];
        end
      end else if (clr_s2_reg) begin
        // Data-less clear token: wipe the run but keep the last products visible.
        o_param_2 <= '0;
        acc_reg   <= '0;
        o_sat     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_comp_mac.sv
// Randomised plus directed bench for comp_mac (4-bit operands, 2 channels, 12-bit accumulator).
// A beat-level model schedules expected outputs three cycles ahead; one process compares every cycle.
module tb_comp_mac;

  localparam int PS = 4;
  localparam int PC = 2;
  localparam int AW = 12;
  localparam int ACC_MAX = (1 << AW) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ena = 1'b0;
  logic              i_mode = 1'b0;
  logic              i_clr = 1'b0;
  logic [PC*PS-1:0]  i_param = '0;
  logic [PC*PS-1:0]  i_param_2 = '0;
  logic [PC*2*PS-1:0] o_param;
  logic [AW-1:0]     o_param_2;
  logic              o_sat;
  logic              dv;

  comp_mac #(.p_size(PS), .p_channels(PC), .p_acc_width(AW)) dut (
    .clk(clk), .rst(rst), .ena(ena), .i_mode(i_mode), .i_clr(i_clr),
    .i_param(i_param), .i_param_2(i_param_2),
    .o_param(o_param), .o_param_2(o_param_2), .o_sat(o_sat), .dv(dv)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                 is_rst;
    bit                 dv;
    logic [PC*2*PS-1:0] op;
    logic [AW-1:0]      op2;
    bit                 sat;
  } exp_t;

  typedef struct packed {
    logic [PC*2*PS-1:0] op;
    logic [AW-1:0]      op2;
    logic               sat;
  } obs_t;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_map [int];
  exp_t cur;
  bit   started = 1'b0;
  obs_t dv_log [$];

  // Model state after every beat driven so far.
  int                 m_acc = 0;
  bit                 m_sat = 1'b0;
  logic [PC*2*PS-1:0] m_op = '0;
  int                 m_op2 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_map.exists(cyc)) begin
      cur = exp_map[cyc];
      exp_map.delete(cyc);
      if (cur.is_rst) started = 1'b1;
    end else begin
      cur.dv = 1'b0;
    end
    if (started) begin
      chk("dv", 64'(dv), 64'(cur.dv));
      chk("o_param", 64'(o_param), 64'(cur.op));
      chk("o_param_2", 64'(o_param_2), 64'(cur.op2));
      chk("o_sat", 64'(o_sat), 64'(cur.sat));
      if (dv === 1'b1) dv_log.push_back('{o_param, o_param_2, o_sat});
    end
  end

  task automatic drive(input bit e, input bit mode, input bit clr,
                       input logic [PC*PS-1:0] a, input logic [PC*PS-1:0] b);
    exp_t x;
    int   sum;
    int   p;
    @(posedge clk);
    #1;
    rst = 1'b0; ena = e; i_mode = mode; i_clr = clr; i_param = a; i_param_2 = b;
    x.is_rst = 1'b0;
    if (e) begin
      sum = 0;
      for (int k = 0; k < PC; k++) begin
        p = int'(a[k*PS +: PS]) * int'(b[k*PS +: PS]);
        m_op[k*2*PS +: 2*PS] = p[2*PS-1:0];
        sum += p;
      end
      if (!mode || clr) begin
        m_acc = sum;
        m_sat = 1'b0;
      end else if (m_acc + sum > ACC_MAX) begin
        m_acc = ACC_MAX;
        m_sat = 1'b1;
      end else begin
        m_acc = m_acc + sum;
      end
      m_op2 = m_acc;
      x.dv = 1'b1; x.op = m_op; x.op2 = m_op2[AW-1:0]; x.sat = m_sat;
      exp_map[cyc + 3] = x;
    end else if (clr) begin
      m_acc = 0; m_sat = 1'b0; m_op2 = 0;
      x.dv = 1'b0; x.op = m_op; x.op2 = '0; x.sat = 1'b0;
      exp_map[cyc + 3] = x;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset(input int n);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b1; ena = 1'b0; i_clr = 1'b0;
      foreach (exp_map[k]) if (k > cyc) exp_map.delete(k);
      m_acc = 0; m_sat = 1'b0; m_op = '0; m_op2 = 0;
      x.is_rst = 1'b1; x.dv = 1'b0; x.op = '0; x.op2 = '0; x.sat = 1'b0;
      exp_map[cyc + 1] = x;
    end
  endtask

  initial begin
    int v;
    // 1. Reset
    do_reset(2);
    @(negedge clk);
    chk("rst_dv", 64'(dv), 64'd0);
    chk("rst_o_param", 64'(o_param), 64'd0);
    chk("rst_o_param_2", 64'(o_param_2), 64'd0);
    chk("rst_o_sat", 64'(o_sat), 64'd0);
    idle(5);
    chk("rst_idle_no_dv", 64'(dv_log.size()), 64'd0);

    // 2. Multiply mode
    dv_log.delete();
    drive(1'b1, 1'b0, 1'b0, 8'hF3, 8'hF5);
    idle(4);
    chk("mul_dv_count", 64'(dv_log.size()), 64'd1);
    if (dv_log.size() == 1) begin
      chk("mul_ch0", 64'(dv_log[0].op[7:0]), 64'd15);
      chk("mul_ch1", 64'(dv_log[0].op[15:8]), 64'd225);
      chk("mul_dot", 64'(dv_log[0].op2), 64'd240);
      chk("mul_sat", 64'(dv_log[0].sat), 64'd0);
    end

    // 3. Accumulate and saturate, then a mode-0 beat drops the flag
    dv_log.delete();
    drive(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF);
    for (int i = 0; i < 17; i++) drive(1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF);
    drive(1'b1, 1'b0, 1'b0, 8'h11, 8'h11);
    idle(4);
    chk("acc_dv_count", 64'(dv_log.size()), 64'd19);
    if (dv_log.size() == 19) begin
      for (int i = 0; i < 18; i++) begin
        v = 450 * (i + 1);
        chk("acc_value", 64'(dv_log[i].op2), 64'((v > 4095) ? 4095 : v));
        chk("acc_sat", 64'(dv_log[i].sat), 64'((i >= 9) ? 1 : 0));
      end
      chk("acc_mode0_value", 64'(dv_log[18].op2), 64'd2);
      chk("acc_mode0_sat", 64'(dv_log[18].sat), 64'd0);
    end

    // 4. Throughput: four back-to-back beats
    dv_log.delete();
    drive(1'b1, 1'b0, 1'b0, 8'h21, 8'h43);
    drive(1'b1, 1'b0, 1'b0, 8'h65, 8'h87);
    drive(1'b1, 1'b0, 1'b0, 8'h22, 8'h22);
    drive(1'b1, 1'b0, 1'b0, 8'h1F, 8'h32);
    idle(4);
    chk("tput_dv_count", 64'(dv_log.size()), 64'd4);
    if (dv_log.size() == 4) begin
      chk("tput_b0", 64'(dv_log[0].op2), 64'd11);
      chk("tput_b1", 64'(dv_log[1].op2), 64'd83);
      chk("tput_b2", 64'(dv_log[2].op2), 64'd8);
      chk("tput_b3", 64'(dv_log[3].op2), 64'd33);
    end

    // 5. Reset mid-flight
    dv_log.delete();
    drive(1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF);
    do_reset(1);
    idle(5);
    chk("rstmid_no_dv", 64'(dv_log.size()), 64'd0);
    chk("rstmid_o_param_2", 64'(o_param_2), 64'd0);
    chk("rstmid_o_param", 64'(o_param), 64'd0);

    // 6. Clear without data
    dv_log.delete();
    drive(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF);
    drive(1'b0, 1'b0, 1'b1, '0, '0);
    idle(2);
    @(posedge clk);
    @(negedge clk);
    chk("clr_o_param_2", 64'(o_param_2), 64'd0);
    chk("clr_dv", 64'(dv), 64'd0);
    drive(1'b1, 1'b1, 1'b0, 8'h03, 8'h05);
    idle(4);
    chk("clr_dv_count", 64'(dv_log.size()), 64'd2);
    if (dv_log.size() == 2) begin
      chk("clr_before", 64'(dv_log[0].op2), 64'd450);
      chk("clr_after", 64'(dv_log[1].op2), 64'd15);
    end

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset(1);
      end else begin
        logic [7:0] a, b;
        a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(200, 255)) : 8'($urandom);
        b = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(200, 255)) : 8'($urandom);
        drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 11) == 0), a, b);
      end
    end
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
